// File: rtl/crossing_request.sv
// Push-button front end for the crossing controller: synchronises and debounces the
// button, holds start until the walk phase is seen, and queues presses made during a walk.
module crossing_request #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned HOLDOFF_CYCLES  = 8,
    parameter logic [4:0]  WALK_PATTERN    = 5'b10100
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       button,
    input  logic [4:0] lightseq,
    output logic       start,
    output logic       wait_lamp,
    output logic [7:0] req_count
);

    localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned HW = $clog2(HOLDOFF_CYCLES + 1);
    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLDOFF_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, PENDING, SERVING, HOLDOFF} state_t;

    logic          sync_p0, sync_p1;
    logic          level;
    logic [DW-1:0] db_cnt;
    logic          press_evt;

    state_t        state, state_n;
    logic          queued, queued_n;
    logic [HW-1:0] hold_cnt, hold_cnt_n;
    logic [7:0]    count_n;
    logic          walk;

    // Synchroniser stage 0 -> 1, then debounce on the synchronised sample
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            level   <= 1'b0;
            db_cnt  <= '0;
        end else begin
            sync_p0 <= button;
            sync_p1 <= sync_p0;
            if (sync_p1 == level) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                level  <= sync_p1;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    // High in the cycle whose closing edge flips the debounced level from 0 to 1
    assign press_evt = !level && sync_p1 && (db_cnt == DB_LAST);
    assign walk      = (lightseq == WALK_PATTERN);

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            queued    <= 1'b0;
            hold_cnt  <= '0;
            req_count <= 8'd0;
        end else begin
            state     <= state_n;
            queued    <= queued_n;
            hold_cnt  <= hold_cnt_n;
            req_count <= count_n;
        end
    end

    always_comb begin
        state_n    = state;
        queued_n   = queued;
        hold_cnt_n = hold_cnt;
        count_n    = req_count;
        unique case (state)
            IDLE: begin
                if (press_evt) state_n = PENDING;
            end
            PENDING: begin
                if (walk) state_n = SERVING;
            end
            SERVING: begin
                if (press_evt) queued_n = 1'b1;
                if (!walk) begin
                    state_n    = HOLDOFF;
                    hold_cnt_n = HOLD_LOAD;
                    if (req_count != 8'hFF) count_n = req_count + 8'd1;
                end
            end
            HOLDOFF: begin
                if (hold_cnt == '0) begin
                    // A press landing on the exit cycle still counts as queued
                    if (queued || press_evt) begin
                        state_n  = PENDING;
                        queued_n = 1'b0;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    hold_cnt_n = hold_cnt - 1'b1;
                    if (press_evt) queued_n = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign start     = (state == PENDING);
    assign wait_lamp = (state == PENDING) || queued;

endmodule

// File: tb/tb_crossing_request.sv
// Directed bench for crossing_request: debounce latency, glitch rejection, walk service,
// queued reissue after hold-off, reset mid-operation and req_count saturation.
module tb_crossing_request;

    logic       clock = 1'b0;
    logic       reset;
    logic       button;
    logic [4:0] lightseq;
    logic       start;
    logic       wait_lamp;
    logic [7:0] req_count;

    int checks = 0;
    int errors = 0;

    localparam logic [4:0] WALK = 5'b10100;

    crossing_request dut (
        .clock    (clock),
        .reset    (reset),
        .button   (button),
        .lightseq (lightseq),
        .start    (start),
        .wait_lamp(wait_lamp),
        .req_count(req_count)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full request from IDLE: press, walk, walk ends, hold-off back to IDLE
    task automatic serve_one();
        button = 1'b1;
        ticks(6);
        button = 1'b0;
        lightseq = WALK;
        tick();
        lightseq = 5'b00000;
        tick();
        ticks(8);
    endtask

    initial begin
        // Test 1: reset with button held, then debounce latency 2+4
        reset = 1'b1;
        button = 1'b1;
        lightseq = 5'b00000;
        ticks(3);
        reset = 1'b0;
        check("rst_start", start, 0);
        check("rst_wait", wait_lamp, 0);
        check("rst_count", req_count, 0);
        for (int i = 1; i <= 6; i++) begin
            tick();
            check($sformatf("lat_start_%0d", i), start, (i >= 6) ? 1 : 0);
            check($sformatf("lat_wait_%0d", i), wait_lamp, (i >= 6) ? 1 : 0);
        end

        // Test 3: full cycle through the light sequence
        lightseq = 5'b01001;
        tick();
        check("seq1_start", start, 1);
        lightseq = 5'b10010;
        tick();
        check("seq2_start", start, 1);
        lightseq = WALK;
        tick();
        check("walk_start_drop", start, 0);
        check("walk_wait", wait_lamp, 0);
        check("walk_count", req_count, 0);
        lightseq = 5'b01100;
        button = 1'b0;
        tick();
        check("end_count", req_count, 1);
        check("end_start", start, 0);
        ticks(7);
        check("hold_start", start, 0);
        tick();
        check("idle_start", start, 0);
        check("idle_wait", wait_lamp, 0);

        // Test 2: 3-cycle glitch is rejected
        ticks(4);
        button = 1'b1;
        ticks(3);
        button = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("glitch_start", start, 0);
        end
        check("glitch_wait", wait_lamp, 0);

        // Test 4: press during walk is queued and reissued after the hold-off
        button = 1'b1;
        ticks(6);
        check("p4_start", start, 1);
        lightseq = WALK;
        tick();
        check("p4_serving", start, 0);
        button = 1'b0;
        ticks(8);
        button = 1'b1;
        ticks(5);
        check("q_before", wait_lamp, 0);
        tick();
        check("q_wait", wait_lamp, 1);
        check("q_start", start, 0);
        button = 1'b0;
        lightseq = 5'b01100;
        tick();
        check("q_count", req_count, 2);
        for (int k = 1; k <= 7; k++) begin
            tick();
            check($sformatf("q_hold_start_%0d", k), start, 0);
            check($sformatf("q_hold_wait_%0d", k), wait_lamp, 1);
        end
        tick();
        check("q_reissue_start", start, 1);
        check("q_reissue_wait", wait_lamp, 1);
        lightseq = WALK;
        tick();
        check("q_cleared", wait_lamp, 0);
        lightseq = 5'b00000;
        tick();
        check("q_count3", req_count, 3);
        ticks(8);
        check("q_idle", start, 0);

        // Test 5a: reset while PENDING
        button = 1'b1;
        ticks(6);
        check("r1_pending", start, 1);
        reset = 1'b1;
        button = 1'b0;
        tick();
        check("r1_start", start, 0);
        check("r1_wait", wait_lamp, 0);
        check("r1_count", req_count, 0);
        reset = 1'b0;
        ticks(10);
        check("r1_norequest", start, 0);

        // Test 5b: reset while HOLDOFF with a queued request
        button = 1'b1;
        ticks(6);
        check("r2_pending", start, 1);
        button = 1'b0;
        lightseq = WALK;
        tick();
        ticks(8);
        button = 1'b1;
        ticks(6);
        check("r2_queued", wait_lamp, 1);
        button = 1'b0;
        lightseq = 5'b00000;
        tick();
        check("r2_count", req_count, 1);
        ticks(2);
        reset = 1'b1;
        tick();
        check("r2_start", start, 0);
        check("r2_wait", wait_lamp, 0);
        check("r2_countclr", req_count, 0);
        reset = 1'b0;
        ticks(12);
        check("r2_norequest", start, 0);
        check("r2_nowait", wait_lamp, 0);

        // Test 6: req_count saturation
        for (int n = 1; n <= 256; n++) begin
            serve_one();
            if (n == 1 || n == 254 || n == 255 || n == 256)
                check($sformatf("sat_%0d", n), req_count, (n > 255) ? 255 : n);
        end
        check("sat_idle", start, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
